// File: rtl/fd_corner_collector.sv
// Corner collector behind the FAST-9 detector: scores each flagged corner in a
// 2-stage pipeline, queues {address, score} in a FIFO and exposes it on valid/ready.
module fd_corner_collector #(
  parameter int ADDR_W  = 15,
  parameter int DEPTH   = 16,
  parameter int SCORE_W = 12
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     isCorner,
  input  logic [ADDR_W-1:0]        refAddr,
  input  logic [7:0]               refPixel,
  input  logic [127:0]             adjPixel,
  input  logic [7:0]               thres,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [SCORE_W-1:0]       out_score,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              corner_count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

  logic                v1, v2;
  logic [ADDR_W-1:0]   addr1, addr2;
  logic [7:0]          adjArr [16];
  logic [7:0]          diff   [16];
  logic [7:0]          tNext  [16];
  logic [7:0]          t1     [16];
  logic [SCORE_W-1:0]  scoreSum, score2;

  logic [ADDR_W-1:0]   memAddr  [DEPTH];
  logic [SCORE_W-1:0]  memScore [DEPTH];
  logic [PTR_W-1:0]    wrPtr, rdPtr;
  logic [PTR_W:0]      count;
  logic                full, push, pop;

  // Per-pixel excess of the absolute difference over the threshold.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      adjArr[i] = adjPixel[8*i +: 8];
      diff[i]   = (adjArr[i] > refPixel) ? adjArr[i] - refPixel : refPixel - adjArr[i];
      tNext[i]  = (diff[i] > thres) ? diff[i] - thres : 8'd0;
    end
  end

  always_comb begin
    scoreSum = '0;
    for (int i = 0; i < 16; i++) begin
      scoreSum = scoreSum + SCORE_W'(t1[i]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v1     <= 1'b0;
      addr1  <= '0;
      t1     <= '{default: 8'd0};
      v2     <= 1'b0;
      addr2  <= '0;
      score2 <= '0;
    end else if (clear) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= isCorner;
      if (isCorner) begin
        addr1 <= refAddr;
        t1    <= tNext;
      end
      v2 <= v1;
      if (v1) begin
        addr2  <= addr1;
        score2 <= scoreSum;
      end
    end
  end

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign full      = (count == FULL_COUNT);
  // When full, a same-cycle pop frees the slot the write pointer is aimed at.
  assign push      = v2 && (!full || pop);

  always_ff @(posedge clock) begin
    if (push && !clear) begin
      memAddr[wrPtr]  <= addr2;
      memScore[wrPtr] <= score2;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (v2 && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      corner_count <= '0;
    end else if (clear) begin
      corner_count <= '0;
    end else if (isCorner && corner_count != 16'hFFFF) begin
      corner_count <= corner_count + 16'd1;
    end
  end

  // Gating on out_valid keeps the head outputs at zero while empty.
  assign out_addr   = out_valid ? memAddr[rdPtr]  : '0;
  assign out_score  = out_valid ? memScore[rdPtr] : '0;
  assign fifo_count = count;

endmodule

// File: doc/fd_corner_collector.md
# fd_corner_collector

Downstream consumer of the FAST-9 detector (`FD_Top`). On every cycle the detector flags a corner, this block:
- computes a 12-bit corner score from the reference pixel, the 16 circle pixels and the threshold, in a 2-stage pipeline;
- pushes `{address, score}` into a small FIFO;
- presents the FIFO entries on a valid/ready port for the later non-max-suppression and host-readout stages.

It also keeps a saturating corner counter and a sticky overflow flag for debug.

## Interface
Parameters
- `ADDR_W`, 15: width of the pixel address (`refAddr`).
- `DEPTH`, 16: FIFO entries; must be a power of two, at least 2.
- `SCORE_W`, 12: score width. Fixed by arithmetic: 16 × 255 = 4080 fits in 12 bits.

Ports
- `clock`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `clear`, in, 1: synchronous flush at frame start. Same effect as `reset`, on the edge.
- `isCorner`, in, 1: detector strobe; the other detector inputs are valid when this is 1.
- `refAddr`, in, `ADDR_W`: address of the centre pixel.
- `refPixel`, in, 8: centre pixel intensity.
- `adjPixel`, in, 128: 16 circle pixels; pixel i is bits [8i+7:8i].
- `thres`, in, 8: detection threshold.
- `out_valid`, out, 1: the head FIFO entry is available.
- `out_ready`, in, 1: consumer accepts the head entry.
- `out_addr`, out, `ADDR_W`: address of the head entry.
- `out_score`, out, `SCORE_W`: score of the head entry.
- `fifo_count`, out, log2(`DEPTH`)+1: number of occupied entries.
- `corner_count`, out, 16: corners seen since reset/clear; saturates at 0xFFFF. Counts dropped corners too.
- `overflow`, out, 1: sticky; set when a corner is dropped because the FIFO is full.

## Operation
Stage 1 (S1) registers, when `isCorner` is 1:
- `v1 <= isCorner`, every cycle.
- `addr1 <= refAddr`.
- `t_i <= (d_i > thres) ? d_i - thres : 0`, where `d_i = |adjPixel_i - refPixel|`.
  - Each `d_i` is an 8-bit unsigned absolute difference, 0..255.
  - `d_i == thres` gives 0.

Stage 2 (S2) registers:
- `v2 <= v1`, `addr2 <= addr1`.
- `score2 <= sum of t_0..t_15`, zero-extended to 12 bits; no overflow is possible.

Data registers in S1/S2 are don't-care while the matching valid bit is 0.

FIFO write happens when `v2 = 1`:
- Write is accepted if `fifo_count < DEPTH`, or if `fifo_count == DEPTH` and a pop occurs in the same cycle.
- Otherwise the entry is dropped and `overflow <= 1`.

FIFO read:
- Pop occurs when `out_valid && out_ready`.
- `out_valid = (fifo_count != 0)`.
- `out_addr`/`out_score` show the entry at the read pointer. They are stable while `out_valid && !out_ready`.

Simultaneous push and pop: `fifo_count` is unchanged and both pointers advance.

Pointers are log2(`DEPTH`) bits and wrap modulo `DEPTH`.

`corner_count` increments by 1 on each cycle `isCorner` = 1, saturating at 0xFFFF.

`clear`:
- Zeroes `v1`, `v2`, both pointers, `fifo_count`, `corner_count` and `overflow`.
- In-flight pipeline corners are discarded.
- Takes priority over `isCorner`, push and pop in the same cycle.

## Timing
- Reset values:
  - `out_valid` = 0, `fifo_count` = 0, `corner_count` = 0, `overflow` = 0.
  - `out_addr` = 0, `out_score` = 0.
  - `v1` = `v2` = 0.
- Latency: `isCorner` sampled at edge E0 → S1 at E0, S2 at E1, FIFO write at E2 → `out_valid` = 1 after E2 if the FIFO was empty.
- Throughput: one corner per cycle, sustained indefinitely while `out_ready` = 1.
- Pop at edge E: the next entry (or `out_valid` = 0) is visible after E.
- An asynchronous `reset` mid-pipeline drops all in-flight and stored entries immediately. Outputs return to reset values without waiting for a clock edge.

## Test plan
1. Reset, then one corner with `refPixel`=0x80, `thres`=0x10, all adj=0xFF, `refAddr`=0x1234 → three edges later `out_valid`=1, `out_addr`=0x1234, `out_score`=0x6F0 (16 × 111). Pop → `out_valid`=0.
2. Even-index adj=0x00, odd-index adj=0x80, `refPixel`=0x80, `thres`=0x10 → score 0x380 (8 × 112). All adj = `refPixel` + 0x10 with `thres`=0x10 → score 0.
3. `out_ready`=0, 20 back-to-back corners, addresses 0..19 → `fifo_count`=16, `overflow`=1, `corner_count`=20. Drain → addresses 0..15 in order with no gaps.
4. FIFO full, then a push arrives in the same cycle as a pop → push accepted, `fifo_count` stays 16, `overflow` stays 0.
5. Continuous corners with `out_ready`=1 for 40 cycles → every address emitted exactly once and in order; pointer wrap at 16 is exercised.
6. Assert `clear` while S1/S2 are valid and the FIFO holds 5 entries → next cycle `fifo_count`=0, `out_valid`=0, `corner_count`=0, and no stale entry appears afterwards. Pulse `reset` mid-stream → same result, asynchronously.
